// File: rtl/result_pkg.sv
// Shared definitions for the result streaming path and the storage-side logic.
package result_pkg;

    localparam int RESULT_MAX_WORDS = 8192;
    localparam int RESULT_DATA_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } stream_state_e;

    function automatic logic [31:0] clamp_count(input logic [31:0] count,
                                                input logic [31:0] limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry output FIFO between the storage read port and the stream interface.
module result_skid_fifo #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [1:0][W-1:0] mem_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // The caller never pushes when full nor pops when empty.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/result_streamer.sv
// Streams a block of words from a 1-cycle-latency storage port onto an AXI-Stream style master.
module result_streamer
    import result_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int MAX_WORDS = RESULT_MAX_WORDS
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [31:0] COUNT,
    input  logic        ABORT,
    output logic [31:0] READ_ADDR,
    input  logic [31:0] READ_DOUT,
    output logic [31:0] M_TDATA,
    output logic        M_TVALID,
    input  logic        M_TREADY,
    output logic        M_TLAST,
    output logic        BUSY,
    output logic        DONE
);

    // One extra bit so a full MAX_WORDS transfer can count to len without wrapping.
    localparam int CW = $clog2(MAX_WORDS) + 1;

    stream_state_e state_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] len_d;
    logic [CW-1:0] rd_idx_q;
    logic [CW-1:0] sent_q;
    logic          inflight_q;
    logic          busy_q;
    logic          done_q;

    logic [1:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic          push;
    logic          pop;
    logic          issue;
    logic          accept;
    logic          abort_act;
    logic          last_hs;
    logic [2:0]    occ;

    assign len_d = CW'(clamp_count(COUNT, 32'(MAX_WORDS)));

    assign M_TVALID  = ~fifo_empty;
    assign M_TDATA   = fifo_dout;
    assign M_TLAST   = M_TVALID && (sent_q == len_q - CW'(1));
    assign READ_ADDR = 32'(rd_idx_q[ADDR_BITS-1:0]);
    assign BUSY      = busy_q;
    assign DONE      = done_q;

    assign pop       = M_TVALID & M_TREADY;
    assign push      = inflight_q & (~fifo_full | pop);
    assign last_hs   = pop & M_TLAST;
    assign abort_act = ABORT && (state_q != ST_IDLE);
    assign accept    = START && !ABORT && (state_q == ST_IDLE) && !busy_q;

    // Reads are throttled so queued plus in-flight words never exceed the FIFO depth.
    assign occ   = 3'(fifo_count) + 3'(inflight_q);
    assign issue = (state_q == ST_RUN) && (rd_idx_q < len_q) && (occ < 3'd2 + 3'(pop));

    result_skid_fifo #(
        .W(RESULT_DATA_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr_i   (abort_act),
        .push_i  (push),
        .din_i   (READ_DOUT),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rd_idx_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                rd_idx_q <= rd_idx_q + CW'(1);
            end
            if (pop) begin
                sent_q <= sent_q + CW'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (accept) begin
                        len_q    <= len_d;
                        rd_idx_q <= '0;
                        sent_q   <= '0;
                        busy_q   <= 1'b1;
                        // Empty transfer: BUSY and DONE for a single cycle, no RUN.
                        if (len_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN, ST_FLUSH: begin
                    if (last_hs) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (state_q == ST_RUN && rd_idx_q == len_q) begin
                        state_q <= ST_FLUSH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (abort_act) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                inflight_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Randomized self-checking bench for result_streamer against a word-list model of the transfer.
module tb_result_streamer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic [31:0] COUNT;
    logic        ABORT;
    logic [31:0] READ_ADDR;
    logic [31:0] READ_DOUT;
    logic [31:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        M_TLAST;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem [0:8191];

    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_cyc[$];
    int          done_cyc[$];
    int          busy_cnt  = 0;
    int          valid_cnt = 0;

    result_streamer #(.ADDR_BITS(13), .MAX_WORDS(8192)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .COUNT     (COUNT),
        .ABORT     (ABORT),
        .READ_ADDR (READ_ADDR),
        .READ_DOUT (READ_DOUT),
        .M_TDATA   (M_TDATA),
        .M_TVALID  (M_TVALID),
        .M_TREADY  (M_TREADY),
        .M_TLAST   (M_TLAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Storage model: data valid one cycle after the address.
    always @(posedge CLK) READ_DOUT <= mem[READ_ADDR[12:0]];

    // Passive recorder of handshakes and pulses; the tests compare its history.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (M_TVALID && M_TREADY) begin
                q_data.push_back(M_TDATA);
                q_last.push_back(M_TLAST);
                q_cyc.push_back(cyc);
            end
            if (DONE)     done_cyc.push_back(cyc);
            if (BUSY)     busy_cnt++;
            if (M_TVALID) valid_cnt++;
        end
    end

    task automatic start_xfer(input int unsigned cnt);
        START = 1'b1;
        COUNT = cnt;
        @(posedge CLK); #1;
        START = 1'b0;
        COUNT = $urandom;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            M_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge CLK); #1;
            if (DONE) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: DONE seen=%0b, required 1 within %0d cycles", seen, budget);
        end
        @(negedge CLK); #1;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; START = 1'b0; COUNT = '0; ABORT = 1'b0; M_TREADY = 1'b0;
        #1;
        checks++;
        if ({READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE} !== '0) begin
            errors++;
            $display("FAIL reset_async: addr=%h data=%h v=%b l=%b busy=%b done=%b, required all 0",
                     READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE} !== '0) begin
            errors++;
            $display("FAIL reset_clocked: addr=%h data=%h v=%b l=%b busy=%b done=%b, required all 0",
                     READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE);
        end
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_basic4;
        int b0 = q_data.size();
        int d0 = done_cyc.size();
        logic [2:0] vb;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
        M_TREADY = 1'b1;
        start_xfer(4);
        vb[0] = M_TVALID;
        @(posedge CLK); #1; vb[1] = M_TVALID;
        @(posedge CLK); #1; vb[2] = M_TVALID;
        checks++;
        if (vb !== 3'b100 || M_TDATA !== 32'hA0) begin
            errors++;
            $display("FAIL basic_latency: valid history=%b data=%h, required 100 and a0", vb, M_TDATA);
        end
        wait_done(20, 1'b0);
        checks++;
        if (q_data.size() - b0 != 4) begin
            errors++;
            $display("FAIL basic_beats: got %0d beats, required 4", q_data.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_data[b0+i] !== 32'hA0 + 32'(i) || q_last[b0+i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_word%0d: data=%h last=%b, required %h last=%b",
                             i, q_data[b0+i], q_last[b0+i], 32'hA0 + 32'(i), i == 3);
                end
            end
            checks++;
            if (q_cyc[b0+3] - q_cyc[b0] != 3) begin
                errors++;
                $display("FAIL basic_gapless: first-to-last span %0d cycles, required 3",
                         q_cyc[b0+3] - q_cyc[b0]);
            end
            checks++;
            if (done_cyc.size() - d0 != 1 || done_cyc[d0] != q_cyc[b0+3] + 1) begin
                errors++;
                $display("FAIL basic_done: %0d pulses, first at cycle %0d, required 1 at cycle %0d",
                         done_cyc.size() - d0, (done_cyc.size() > d0) ? done_cyc[d0] : -1, q_cyc[b0+3] + 1);
            end
        end
    endtask

    task automatic test_backpressure16;
        int b0 = q_data.size();
        int d0 = done_cyc.size();
        int nlast = 0;
        int nbad  = 0;
        bit seen  = 1'b0;
        bit stall;
        logic [31:0] pdata;
        logic        plast;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        M_TREADY = 1'b0;
        start_xfer(16);
        for (int i = 0; i < 400 && !seen; i++) begin
            M_TREADY = 1'($urandom_range(0, 1));
            stall = M_TVALID && !M_TREADY;
            pdata = M_TDATA;
            plast = M_TLAST;
            @(posedge CLK); #1;
            if (stall) begin
                checks++;
                if (M_TVALID !== 1'b1 || M_TDATA !== pdata || M_TLAST !== plast) begin
                    errors++;
                    $display("FAIL bp_hold: v=%b data=%h last=%b, required v=1 data=%h last=%b",
                             M_TVALID, M_TDATA, M_TLAST, pdata, plast);
                end
            end
            if (DONE) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout: DONE seen=%0b, required 1", seen);
        end
        @(negedge CLK); #1;
        checks++;
        if (q_data.size() - b0 != 16) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats, required 16", q_data.size() - b0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (q_data[b0+i] !== mem[i]) nbad++;
                if (q_last[b0+i]) nlast++;
            end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL bp_order: %0d words differ from storage 0..15, required 0", nbad);
            end
            checks++;
            if (nlast != 1 || !q_last[b0+15]) begin
                errors++;
                $display("FAIL bp_tlast: %0d TLAST beats, on final=%b, required 1 on final",
                         nlast, q_last[b0+15]);
            end
        end
        checks++;
        if (done_cyc.size() - d0 != 1) begin
            errors++;
            $display("FAIL bp_done: %0d DONE pulses, required 1", done_cyc.size() - d0);
        end
    endtask

    task automatic test_zero;
        int d0 = done_cyc.size();
        int v0 = valid_cnt;
        int k0 = busy_cnt;
        int s;
        M_TREADY = 1'b1;
        start_xfer(0);
        s = cyc;
        repeat (5) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL zero_valid: TVALID high %0d cycles, required 0", valid_cnt - v0);
        end
        checks++;
        if (done_cyc.size() - d0 != 1 || done_cyc[d0] != s) begin
            errors++;
            $display("FAIL zero_done: %0d pulses, first at cycle %0d, required 1 at cycle %0d",
                     done_cyc.size() - d0, (done_cyc.size() > d0) ? done_cyc[d0] : -1, s);
        end
        checks++;
        if (busy_cnt - k0 != 1) begin
            errors++;
            $display("FAIL zero_busy: BUSY high %0d cycles, required 1", busy_cnt - k0);
        end
    endtask

    task automatic test_max;
        int b0 = q_data.size();
        int n;
        int nbad  = 0;
        int nlast = 0;
        int maxa  = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        M_TREADY = 1'b1;
        start_xfer(9000);
        for (int i = 0; i < 8400 && !seen; i++) begin
            if (int'(READ_ADDR) > maxa) maxa = int'(READ_ADDR);
            @(posedge CLK); #1;
            if (DONE) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL max_timeout: DONE seen=%0b, required 1", seen);
        end
        @(negedge CLK); #1;
        n = q_data.size() - b0;
        checks++;
        if (n != 8192) begin
            errors++;
            $display("FAIL max_beats: got %0d beats, required 8192", n);
        end else begin
            for (int i = 0; i < 8192; i++) begin
                if (q_data[b0+i] !== mem[i]) nbad++;
                if (q_last[b0+i]) nlast++;
            end
            checks++;
            if (nbad != 0 || nlast != 1 || !q_last[b0+8191]) begin
                errors++;
                $display("FAIL max_content: %0d bad words, %0d TLAST, final last=%b, required 0/1/1",
                         nbad, nlast, q_last[b0+8191]);
            end
        end
        checks++;
        if (maxa != 8191) begin
            errors++;
            $display("FAIL max_addr: highest READ_ADDR %0d, required 8191", maxa);
        end
    endtask

    task automatic test_abort;
        int b0 = q_data.size();
        int d0 = done_cyc.size();
        int b1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 + 32'(i * 7 + 3);
        M_TREADY = 1'b0;
        start_xfer(10);
        for (int i = 0; i < 10 && !M_TVALID; i++) begin
            @(posedge CLK); #1;
        end
        M_TREADY = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        M_TREADY = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        checks++;
        if (M_TVALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: v=%b busy=%b after abort, required 0 0", M_TVALID, BUSY);
        end
        repeat (5) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (q_data.size() - b0 != 3 || q_data[b0] !== mem[0] || q_data[b0+2] !== mem[2]) begin
            errors++;
            $display("FAIL abort_beats: got %0d beats before abort, required 3 from address 0",
                     q_data.size() - b0);
        end
        checks++;
        if (done_cyc.size() != d0) begin
            errors++;
            $display("FAIL abort_nodone: %0d DONE pulses, required 0", done_cyc.size() - d0);
        end
        b1 = q_data.size();
        M_TREADY = 1'b1;
        start_xfer(2);
        wait_done(30, 1'b0);
        checks++;
        if (q_data.size() - b1 != 2 || q_data[b1] !== mem[0] || q_data[b1+1] !== mem[1]) begin
            errors++;
            $display("FAIL abort_restart: %0d beats first=%h, required 2 beats %h %h",
                     q_data.size() - b1, (q_data.size() > b1) ? q_data[b1] : 32'h0, mem[0], mem[1]);
        end
    endtask

    task automatic test_start_busy;
        int b0 = q_data.size();
        int d0 = done_cyc.size();
        int nbad = 0;
        int nlast = 0;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        M_TREADY = 1'b1;
        start_xfer(6);
        @(posedge CLK); #1;
        start_xfer(3);
        wait_done(200, 1'b1);
        M_TREADY = 1'b1;
        repeat (8) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (q_data.size() - b0 != 6) begin
            errors++;
            $display("FAIL busy_start_beats: got %0d beats, required 6", q_data.size() - b0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (q_data[b0+i] !== mem[i]) nbad++;
                if (q_last[b0+i]) nlast++;
            end
            checks++;
            if (nbad != 0 || nlast != 1 || !q_last[b0+5]) begin
                errors++;
                $display("FAIL busy_start_content: %0d bad words, %0d TLAST, required 0 and 1 on beat 6",
                         nbad, nlast);
            end
        end
        checks++;
        if (done_cyc.size() - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_done: %0d DONE pulses, required 1", done_cyc.size() - d0);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        int b0;
        M_TREADY = 1'b1;
        d0 = done_cyc.size();
        start_xfer(20);
        repeat (5) begin @(posedge CLK); #1; end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: addr=%h data=%h v=%b l=%b busy=%b done=%b, required all 0",
                     READ_ADDR, M_TDATA, M_TVALID, M_TLAST, BUSY, DONE);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (done_cyc.size() != d0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_nodone: %0d DONE pulses busy=%b, required 0 and 0",
                     done_cyc.size() - d0, BUSY);
        end
        b0 = q_data.size();
        start_xfer(3);
        wait_done(30, 1'b0);
        checks++;
        if (q_data.size() - b0 != 3 || q_data[b0] !== mem[0] || q_data[b0+2] !== mem[2] || !q_last[b0+2]) begin
            errors++;
            $display("FAIL midreset_restart: %0d beats, required 3 beats from address 0 ending in TLAST",
                     q_data.size() - b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        test_reset();
        test_basic4();
        test_backpressure16();
        test_zero();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
